pipeline_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. Generates PC enable plus per-latch enable/flush for IF/ID, ID/EX, EX/MEM, MEM/WB from memory hit status, load-use hazards, taken branches and halt. Operand forwarding resolves all other RAW hazards. This block owns only the stall, bubble and squash decisions that forwarding cannot cover.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/load_use_detect.sv | 22 ++
 rtl/pipeline_ctrl.sv | 138 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared core types: register-index width, the hard-wired zero register and
// the pipeline sequencing controller state encoding.
package cpu_types_pkg;

    localparam int REGBITS = 5;
    localparam logic [REGBITS-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        LDSTALL = 2'd2,
        HALTED  = 2'd3
    } pipectrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags a load in EX whose destination is
// read by the instruction in ID, and reports which source operand collides.
module load_use_detect
    import cpu_types_pkg::*;
(
    input  logic               memread_i,
    input  logic [REGBITS-1:0] rt_ex_i,
    input  logic [REGBITS-1:0] rs_id_i,
    input  logic [REGBITS-1:0] rt_id_i,
    output logic               hazard_o,
    output logic [1:0]         which_src_o
);

    logic loadLive;

    // $0 is never written, so a load targeting it can never feed a consumer
    assign loadLive       = memread_i && (rt_ex_i != REG_ZERO);
    assign which_src_o[0] = loadLive && (rt_ex_i == rs_id_i);
    assign which_src_o[1] = loadLive && (rt_ex_i == rt_id_i);
    assign hazard_o       = |which_src_o;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/bubble/squash sequencer for the 5-stage core. Performance counters are
// built only when PIPECTRL_PERF_EN is defined; otherwise the ports read 0.
module pipeline_ctrl
    import cpu_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               dmemren_mem,
    input  logic               dmemwen_mem,
    input  logic               memread_ex,
    input  logic [REGBITS-1:0] rt_ex,
    input  logic [REGBITS-1:0] rs_id,
    input  logic [REGBITS-1:0] rt_id,
    input  logic               branch_taken_ex,
    input  logic               halt_wb,
    output logic               pc_en,
    output logic               if_id_en,
    output logic               id_ex_en,
    output logic               ex_mem_en,
    output logic               mem_wb_en,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               ex_mem_flush,
    output logic               halt,
    output logic [1:0]         state,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        bubbles,
    output logic [31:0]        squashes
);

    pipectrl_state_t state_q, state_d;
    logic            halt_q;
    logic            luHazard;
    logic [1:0]      luWhich;
    logic            ldUse;
    logic            dmemWait;
    logic            active;

    load_use_detect u_load_use_detect (
        .memread_i   (memread_ex),
        .rt_ex_i     (rt_ex),
        .rs_id_i     (rs_id),
        .rt_id_i     (rt_id),
        .hazard_o    (luHazard),
        .which_src_o (luWhich)
    );

    // LDSTALL masks the comparator so each load inserts exactly one bubble
    assign ldUse    = (state_q == RUN) && luHazard && (luWhich != 2'b00);
    assign dmemWait = (dmemren_mem || dmemwen_mem) && !dhit;
    assign active   = (state_q == RUN) || (state_q == LDSTALL);

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_d     = state_q;
        unique case (state_q)
            IDLE:    state_d = RUN;
            HALTED:  state_d = HALTED;
            default: begin
                if (halt_wb) begin
                    state_d = HALTED;
                end else if (dmemWait) begin
                    state_d = state_q;
                end else if (branch_taken_ex) begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = RUN;
                end else if (ldUse) begin
                    {id_ex_en, ex_mem_en, mem_wb_en} = 3'b111;
                    id_ex_flush = 1'b1;
                    state_d     = LDSTALL;
                end else if (!ihit) begin
                    {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
                    if_id_flush = 1'b1;
                    state_d     = RUN;
                end else begin
                    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    state_d = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= (state_d == HALTED);
        end
    end

    assign ex_mem_flush = 1'b0;
    assign halt         = halt_q;
    assign state        = state_q;

`ifdef PIPECTRL_PERF_EN
    logic        stallHit, bubbleHit, squashHit;
    logic [31:0] stallCnt_q, bubbleCnt_q, squashCnt_q;

    assign stallHit  = active && !halt_wb &&
                       (dmemWait || (!branch_taken_ex && !ldUse && !ihit));
    assign bubbleHit = active && !halt_wb && !dmemWait && !branch_taken_ex && ldUse;
    assign squashHit = active && !halt_wb && !dmemWait && branch_taken_ex;

    // Rules only fire in RUN/LDSTALL, so the counts freeze once HALTED
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stallCnt_q  <= '0;
            bubbleCnt_q <= '0;
            squashCnt_q <= '0;
        end else begin
            if (stallHit)  stallCnt_q  <= stallCnt_q + 32'd1;
            if (bubbleHit) bubbleCnt_q <= bubbleCnt_q + 32'd1;
            if (squashHit) squashCnt_q <= squashCnt_q + 32'd1;
        end
    end

    assign stall_cycles = stallCnt_q;
    assign bubbles      = bubbleCnt_q;
    assign squashes     = squashCnt_q;
`else
    assign stall_cycles = 32'd0;
    assign bubbles      = 32'd0;
    assign squashes     = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each directed vector pushes its
// hand-computed response, and a negedge monitor pops and compares it.
module tb_pipeline_ctrl;

    logic        CLK, nRST;
    logic        ihit, dhit, dmemren_mem, dmemwen_mem, memread_ex;
    logic [4:0]  rt_ex, rs_id, rt_id;
    logic        branch_taken_ex, halt_wb;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, halt;
    logic [1:0]  state;
    logic [31:0] stall_cycles, bubbles, squashes;

    typedef struct {
        logic [4:0]  en;
        logic [2:0]  fl;
        logic [1:0]  st;
        logic        hl;
        logic [31:0] sc;
        logic [31:0] bb;
        logic [31:0] sq;
    } exp_t;

    exp_t        expQ[$];
    int          nChecks = 0;
    int          nFails  = 0;
    int          nPushed = 0;
    int          nPopped = 0;
    int          tallyS  = 0;
    int          tallyB  = 0;
    int          tallyQ  = 0;
`ifdef PIPECTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] OFF = 5'b00000;
    localparam logic [4:0] LU  = 5'b00111;
    localparam logic [4:0] IM  = 5'b01111;

    pipeline_ctrl dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .dmemren_mem(dmemren_mem), .dmemwen_mem(dmemwen_mem),
        .memread_ex(memread_ex), .rt_ex(rt_ex), .rs_id(rs_id), .rt_id(rt_id),
        .branch_taken_ex(branch_taken_ex), .halt_wb(halt_wb),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .halt(halt), .state(state),
        .stall_cycles(stall_cycles), .bubbles(bubbles), .squashes(squashes)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the response expected in that cycle
    task automatic applyStimulus(
        input logic ih, dh, dr, dw, mr,
        input logic [4:0] rte, rsi, rti,
        input logic br, hw,
        input logic [4:0] en, input logic [2:0] fl, input logic [1:0] st, input logic hl,
        input int dS, dB, dQ);
        exp_t e;
        ihit = ih; dhit = dh; dmemren_mem = dr; dmemwen_mem = dw; memread_ex = mr;
        rt_ex = rte; rs_id = rsi; rt_id = rti; branch_taken_ex = br; halt_wb = hw;
        e.en = en; e.fl = fl; e.st = st; e.hl = hl;
        e.sc = PERF ? 32'(tallyS) : 32'd0;
        e.bb = PERF ? 32'(tallyB) : 32'd0;
        e.sq = PERF ? 32'(tallyQ) : 32'd0;
        expQ.push_back(e);
        nPushed++;
        tallyS += dS; tallyB += dB; tallyQ += dQ;
        @(posedge CLK); #1;
    endtask

    always @(negedge CLK) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            nPopped++;
            checkOutput("enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e.en));
            checkOutput("flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'(e.fl));
            checkOutput("state", 32'(state), 32'(e.st));
            checkOutput("halt", 32'(halt), 32'(e.hl));
            checkOutput("stall_cycles", stall_cycles, e.sc);
            checkOutput("bubbles", bubbles, e.bb);
            checkOutput("squashes", squashes, e.sq);
        end
    end

    initial begin
        nRST = 1'b0;
        ihit = 1'b1; dhit = 1'b0; dmemren_mem = 1'b0; dmemwen_mem = 1'b0; memread_ex = 1'b0;
        rt_ex = '0; rs_id = '0; rt_id = '0; branch_taken_ex = 1'b0; halt_wb = 1'b0;
        @(posedge CLK); #1;

        //             ih dh dr dw mr rte rsi rti br hw  en   fl      st hl  S B Q
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 3'b000, 0, 0, 0, 0, 0);
        nRST = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 3'b000, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 3'b000, 1, 0, 0, 0, 0);
        // lw $2 then add using $2: one bubble, then LDSTALL masks the repeat
        applyStimulus(1, 0, 0, 0, 1, 2, 2, 7, 0, 0, LU,  3'b010, 1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 1, 2, 2, 7, 0, 0, ALL, 3'b000, 2, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 3'b000, 1, 0, 0, 0, 0);
        // branch beats load-use; flush holds even on an icache miss
        applyStimulus(1, 0, 0, 0, 1, 3, 4, 3, 1, 0, ALL, 3'b110, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, ALL, 3'b110, 1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, ALL, 3'b000, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IM,  3'b100, 1, 0, 1, 0, 0);
        // three-cycle dmem wait, one with an icache miss too
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, OFF, 3'b000, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, OFF, 3'b000, 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, OFF, 3'b000, 1, 0, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, ALL, 3'b000, 1, 0, 0, 0, 0);
        // load-use whose LDSTALL is held by a store wait
        applyStimulus(1, 0, 0, 0, 1, 5, 9, 5, 0, 0, LU,  3'b010, 1, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 1, 1, 5, 9, 5, 0, 0, OFF, 3'b000, 2, 0, 1, 0, 0);
        applyStimulus(1, 1, 0, 1, 1, 5, 9, 5, 0, 0, ALL, 3'b000, 2, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 3'b000, 1, 0, 0, 0, 0);
        // dmem wait outranks load-use in RUN
        applyStimulus(1, 0, 1, 0, 1, 6, 6, 0, 0, 0, OFF, 3'b000, 1, 0, 1, 0, 0);
        // halt during dmem wait, then sticky HALTED ignores everything
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, OFF, 3'b000, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 3'b000, 3, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 1, 2, 2, 2, 1, 0, OFF, 3'b000, 3, 1, 0, 0, 0);
        // asynchronous reset clears state, halt and counters at once
        nRST = 1'b0;
        tallyS = 0; tallyB = 0; tallyQ = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 3'b000, 0, 0, 0, 0, 0);
        nRST = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 3'b000, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IM,  3'b100, 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 3'b000, 1, 0, 0, 0, 0);

        @(posedge CLK); #1;
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        checkOutput("vectors_checked", 32'(nPopped), 32'(nPushed));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
